my_aes_key_sched: RTL

Parametrised AES key schedule supporting 128/192/256-bit keys, selected per `init` by a mode input. It expands the cipher key one 32-bit word per cycle into an internal round-key store of up to 60 words. The store is readable by round index through a registered 128-bit read port, so cipher/decipher datapaths can fetch round keys in any order, including reverse order for decryption. It replaces the single-mode, forward-only, on-the-fly 128-bit key generator in the AES core.

---
 rtl/my_aes_key_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/my_aes_key_sched.sv
// AES key schedule for 128/192/256-bit keys: expands one word per cycle into a
// round-key store that can be read by round index through a registered 128-bit port.
module my_aes_key_sched #(
    parameter bit ENABLE_192      = 1'b1,
    parameter bit ENABLE_256      = 1'b1,
    parameter bit RD_ZERO_INVALID = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [255:0] key,
    input  logic [1:0]   keylen,
    input  logic         init,
    output logic         ready,
    output logic         key_valid,
    output logic [3:0]   num_rounds,
    output logic         init_err,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    typedef enum logic [0:0] {StIdle, StGen} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the AES affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    state_e         state_q, state_d;
    logic [5:0]     i_q, i_d;
    logic [2:0]     phase_q, phase_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [3:0]     nk_q, nk_d;
    logic [3:0]     nr_q, nr_d;
    logic           key_valid_q, key_valid_d;
    logic           init_err_q, init_err_d;
    logic [127:0]   rd_key_q, rd_key_d;
    logic [31:0]    store_q [60];

    logic           mode_ok;
    logic [3:0]     nk_init, nr_init;
    logic           accept;
    logic [31:0]    prev_word, back_word, sub_in, sub_out, temp_word, new_word;
    logic [5:0]     last_idx;
    logic           last_word;
    logic [5:0]     rd_base;

    always_comb begin
        mode_ok = 1'b0;
        nk_init = 4'd4;
        nr_init = 4'd10;
        case (keylen)
            2'b00: mode_ok = 1'b1;
            2'b01: begin
                mode_ok = ENABLE_192;
                nk_init = 4'd6;
                nr_init = 4'd12;
            end
            2'b10: begin
                mode_ok = ENABLE_256;
                nk_init = 4'd8;
                nr_init = 4'd14;
            end
            default: mode_ok = 1'b0;
        endcase
    end

    assign accept = (state_q == StIdle) && init && mode_ok;

    // Single S-box path shared by the RotWord/Rcon step and the 256-bit mid-key step.
    always_comb begin
        prev_word = store_q[i_q - 6'd1];
        back_word = store_q[i_q - {2'b00, nk_q}];
        sub_in    = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        sub_out   = sub_word(sub_in);
        if (phase_q == 3'd0) begin
            temp_word = sub_out ^ {rcon_q, 24'h000000};
        end else if (nk_q == 4'd8 && phase_q == 3'd4) begin
            temp_word = sub_out;
        end else begin
            temp_word = prev_word;
        end
        new_word  = back_word ^ temp_word;
        last_idx  = {nr_q + 4'd1, 2'b00} - 6'd1;
        last_word = (i_q == last_idx);
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        phase_d     = phase_q;
        rcon_d      = rcon_q;
        nk_d        = nk_q;
        nr_d        = nr_q;
        key_valid_d = key_valid_q;
        init_err_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (init) begin
                    if (mode_ok) begin
                        state_d     = StGen;
                        nk_d        = nk_init;
                        nr_d        = nr_init;
                        i_d         = {2'b00, nk_init};
                        phase_d     = 3'd0;
                        rcon_d      = 8'h01;
                        key_valid_d = 1'b0;
                    end else begin
                        init_err_d = 1'b1;
                    end
                end
            end
            StGen: begin
                i_d     = i_q + 6'd1;
                phase_d = ({1'b0, phase_q} == nk_q - 4'd1) ? 3'd0 : phase_q + 3'd1;
                if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
                if (last_word) begin
                    state_d     = StIdle;
                    key_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            i_q         <= 6'd0;
            phase_q     <= 3'd0;
            rcon_q      <= 8'h01;
            nk_q        <= 4'd4;
            nr_q        <= 4'd0;
            key_valid_q <= 1'b0;
            init_err_q  <= 1'b0;
            rd_key_q    <= 128'h0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            phase_q     <= phase_d;
            rcon_q      <= rcon_d;
            nk_q        <= nk_d;
            nr_q        <= nr_d;
            key_valid_q <= key_valid_d;
            init_err_q  <= init_err_d;
            rd_key_q    <= rd_key_d;
        end
    end

    // Store has no reset; only the valid flag qualifies its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(nk_init)) store_q[k] <= key[255 - 32*k -: 32];
            end
        end else if (state_q == StGen) begin
            store_q[i_q] <= new_word;
        end
    end

    always_comb begin
        rd_base  = {rd_round, 2'b00};
        rd_key_d = 128'h0;
        if (rd_round <= 4'd14 &&
            (!RD_ZERO_INVALID || (key_valid_q && rd_round <= nr_q))) begin
            rd_key_d = {store_q[rd_base], store_q[rd_base + 6'd1],
                        store_q[rd_base + 6'd2], store_q[rd_base + 6'd3]};
        end
    end

    assign ready      = (state_q == StIdle);
    assign key_valid  = key_valid_q;
    assign num_rounds = nr_q;
    assign init_err   = init_err_q;
    assign rd_key     = rd_key_q;

endmodule
